regbank_write_arbiter: RTL and testbench
========================================

# regbank_write_arbiter

Arbitrates the single register-bank write port between the main control unit (source A) and a buffered secondary writer (source B, e.g. exception/stack sequencer), and drives the RegDst select of the write-destination mux plus RegWrite and write data. Source A has fixed priority. A starvation counter guarantees B forward progress. Sits between control/writeback logic and the register bank, directly in front of the RegDst mux.

## Interface
- DATA_W, 32, write-data width
- STARVE_MAX, 3, consecutive A grants tolerated while B FIFO non-empty (1..7)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- a_req  in  1  source A write request, held until a_ack
- a_regdst  in  2  source A destination select
- a_data  in  DATA_W  source A write data
- a_ack  out  1  one-cycle pulse, A's write issued this cycle
- b_valid  in  1  source B push strobe
- b_regdst  in  2  source B destination select
- b_data  in  DATA_W  source B write data
- b_ready  out  1  B FIFO can accept (count < 2)
- bank_busy  in  1  write port unavailable; blocks new grants
- RegDst  out  2  mux select: 00 rt, 01 rd, 10 reg 31, 11 reg 30
- wr_data  out  DATA_W  register-bank write data
- RegWrite  out  1  register-bank write enable
- grant_b  out  1  current write belongs to source B

## Operation
- FSM states: IDLE, WRITE. All outputs except b_ready are registered.
- In IDLE, when bank_busy=0, decide:
  - B wins if FIFO non-empty and (a_req=0 or starve_cnt==STARVE_MAX).
  - Else A wins if a_req=1.
  - Else no grant; stay IDLE.
- On a grant: latch RegDst/wr_data from the winner, set RegWrite=1, set grant_b, go to WRITE.
  - B grant pops the FIFO head at the same edge.
- In WRITE: RegWrite=1 for exactly this cycle. a_ack=1 if A won. Next state is IDLE unconditionally. No decision is made in WRITE.
- Leaving WRITE clears RegWrite, a_ack and grant_b. RegDst/wr_data hold their last values.
- B FIFO:
  - 2 entries, each {regdst, data}, in-order.
  - Push when b_valid & b_ready. b_ready = (count<2), combinational from count only.
  - A push and a pop in the same edge leave count unchanged. A push while full is ignored.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each A grant while FIFO non-empty.
  - Clears on a B grant or whenever the FIFO is empty.
- A must hold a_req/a_regdst/a_data stable until a_ack. A may drop or change them the cycle after a_ack. a_req still high during the a_ack cycle is not re-sampled, because the FSM is in WRITE.
- Reset (asynchronous, any time):
  - State IDLE, FIFO empty, starve_cnt=0.
  - RegWrite=0, a_ack=0, grant_b=0, RegDst=00, wr_data=0, b_ready=1.
  - A write in progress is dropped; no ack is issued for it.

## Timing
- Decision at IDLE edge t. RegWrite/a_ack asserted during cycle t+1. Next decision at edge t+2.
- Peak throughput: one write per 2 cycles.
- A latency from a_req (FSM idle, bank free, B not starved): a_ack 1 cycle later.
- B latency from push into an empty FIFO with A idle: entry written is eligible at the next IDLE edge. No same-cycle bypass of the FIFO.
- bank_busy is sampled only in IDLE. Asserting it during WRITE does not cancel the write.
- Worst-case B wait with A saturating: STARVE_MAX A writes, then B's write.

## Test plan
- Reset: assert reset low mid-WRITE (RegWrite=1) -> RegWrite, a_ack, grant_b drop immediately; b_ready=1; RegDst=00.
- Single A write: a_req=1, a_regdst=10, a_data=0x0000_1234 -> next cycle RegWrite=1, RegDst=10, wr_data=0x1234, a_ack=1, grant_b=0; RegWrite=0 the following cycle.
- FIFO order/full: push B entries (11,0xAAAA) and (01,0xBBBB) back-to-back with A idle -> b_ready=0 after the second push; a third push is ignored; writes issue in order 0xAAAA then 0xBBBB, each with grant_b=1, 2 cycles apart.
- Starvation: STARVE_MAX=3, a_req held high continuously (new data each ack), one B entry queued -> exactly 3 A writes, then the B write, then A resumes.
- Collision: A request and B push arrive in the same cycle, FIFO empty, starve_cnt=0 -> A written first, B next.
- bank_busy: hold bank_busy=1 for 4 cycles with a_req=1 -> no RegWrite; grant at the first IDLE edge with bank_busy=0, RegWrite one cycle later.

Source files
------------

// File: rtl/regbank_write_arbiter_if.sv
// Register-bank write port bundle: source A request/ack, source B push
// channel, bank busy, and the arbitrated write toward the RegDst mux.
//   master : drives requests, B pushes and bank_busy; observes the write
//   slave  : the arbiter side
interface regbank_write_arbiter_if #(
    parameter int unsigned DATA_W = 32
);
    logic              a_req;
    logic [1:0]        a_regdst;
    logic [DATA_W-1:0] a_data;
    logic              a_ack;

    logic              b_valid;
    logic [1:0]        b_regdst;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;

    logic              bank_busy;

    logic [1:0]        RegDst;
    logic [DATA_W-1:0] wr_data;
    logic              RegWrite;
    logic              grant_b;

    modport master (
        output a_req, a_regdst, a_data,
        output b_valid, b_regdst, b_data,
        output bank_busy,
        input  a_ack, b_ready, RegDst, wr_data, RegWrite, grant_b
    );

    modport slave (
        input  a_req, a_regdst, a_data,
        input  b_valid, b_regdst, b_data,
        input  bank_busy,
        output a_ack, b_ready, RegDst, wr_data, RegWrite, grant_b
    );
endinterface

// File: rtl/regbank_write_arbiter.sv
// Arbitrates the single register-bank write port between source A (fixed
// priority) and a 2-entry buffered source B, with a starvation counter that
// forces a B grant after STARVE_MAX consecutive A grants.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : slave side of regbank_write_arbiter_if (A req/ack, B push,
//            bank_busy, RegDst/wr_data/RegWrite/grant_b)
module regbank_write_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    regbank_write_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned FIFO_DEPTH = 2;

    typedef enum logic {IDLE, WRITE} state_t;

    typedef struct packed {
        logic [1:0]        regdst;
        logic [DATA_W-1:0] data;
    } b_entry_t;

    state_t            state_q, state_d;
    logic              reg_write_q, reg_write_d;
    logic              a_ack_q, a_ack_d;
    logic              grant_b_q, grant_b_d;
    logic [1:0]        regdst_q, regdst_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [CNT_W-1:0]  starve_q, starve_d;

    b_entry_t          fifo_q [FIFO_DEPTH];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q;
    logic              fifo_ne, b_ready_int, push, pop;
    b_entry_t          head;

    assign b_ready_int = (count_q < 2'd2);
    assign fifo_ne     = (count_q != 2'd0);
    assign push        = bus.b_valid & b_ready_int;
    assign head        = fifo_q[rd_ptr_q];

    // Grant decision in IDLE; WRITE lasts one cycle and always returns to IDLE.
    always_comb begin
        state_d     = state_q;
        reg_write_d = 1'b0;
        a_ack_d     = 1'b0;
        grant_b_d   = 1'b0;
        regdst_d    = regdst_q;
        wr_data_d   = wr_data_q;
        starve_d    = starve_q;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.bank_busy) begin
                    if (fifo_ne && (!bus.a_req || starve_q == CNT_W'(STARVE_MAX))) begin
                        pop         = 1'b1;
                        regdst_d    = head.regdst;
                        wr_data_d   = head.data;
                        reg_write_d = 1'b1;
                        grant_b_d   = 1'b1;
                        state_d     = WRITE;
                    end else if (bus.a_req) begin
                        regdst_d    = bus.a_regdst;
                        wr_data_d   = bus.a_data;
                        reg_write_d = 1'b1;
                        a_ack_d     = 1'b1;
                        state_d     = WRITE;
                    end
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Starvation only accrues while B actually has something waiting.
        if (!fifo_ne || pop) begin
            starve_d = '0;
        end else if (a_ack_d && starve_q != CNT_W'(STARVE_MAX)) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // FSM and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            reg_write_q <= 1'b0;
            a_ack_q     <= 1'b0;
            grant_b_q   <= 1'b0;
            regdst_q    <= 2'b00;
            wr_data_q   <= '0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            reg_write_q <= reg_write_d;
            a_ack_q     <= a_ack_d;
            grant_b_q   <= grant_b_d;
            regdst_q    <= regdst_d;
            wr_data_q   <= wr_data_d;
            starve_q    <= starve_d;
        end
    end

    // B FIFO: push and pop on the same edge leave the count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= '{regdst: bus.b_regdst, data: bus.b_data};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

    assign bus.a_ack    = a_ack_q;
    assign bus.grant_b  = grant_b_q;
    assign bus.RegWrite = reg_write_q;
    assign bus.RegDst   = regdst_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.b_ready  = b_ready_int;
endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Bench for regbank_write_arbiter: reset state, a directed vector table,
// starvation and reset-mid-write sequences, then randomized traffic against
// a queue-based reference model.
module tb_regbank_write_arbiter;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STARVE_MAX = 3;
    localparam int          N_VEC      = 20;
    localparam int          N_RND      = 600;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regbank_write_arbiter_if #(.DATA_W(DATA_W)) bus ();

    regbank_write_arbiter #(.DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        a_req;
        logic [1:0]  a_regdst;
        logic [31:0] a_data;
        logic        b_valid;
        logic [1:0]  b_regdst;
        logic [31:0] b_data;
        logic        busy;
        logic        rw;
        logic        ack;
        logic        gb;
        logic [1:0]  rd;
        logic [31:0] wd;
        logic        br;
    } vec_t;

    vec_t vecs [N_VEC];

    typedef struct {
        logic [1:0]  rd;
        logic [31:0] d;
    } ment_t;

    // Reference model state
    ment_t       m_q[$];
    int          m_starve;
    bit          m_in_write;
    logic        e_rw, e_ack, e_gb, e_br;
    logic [1:0]  e_rd;
    logic [31:0] e_wd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ar, input logic [1:0] ard, input logic [31:0] ad,
                         input logic bv, input logic [1:0] brd, input logic [31:0] bd,
                         input logic busy);
        bus.a_req     = ar;
        bus.a_regdst  = ard;
        bus.a_data    = ad;
        bus.b_valid   = bv;
        bus.b_regdst  = brd;
        bus.b_data    = bd;
        bus.bank_busy = busy;
    endtask

    task automatic check_outs(input string tag, input logic rw, input logic ack, input logic gb,
                              input logic [1:0] rd, input logic [31:0] wd, input logic br);
        check({tag, "_RegWrite"}, 64'(bus.RegWrite), 64'(rw));
        check({tag, "_a_ack"},    64'(bus.a_ack),    64'(ack));
        check({tag, "_grant_b"},  64'(bus.grant_b),  64'(gb));
        check({tag, "_RegDst"},   64'(bus.RegDst),   64'(rd));
        check({tag, "_wr_data"},  64'(bus.wr_data),  64'(wd));
        check({tag, "_b_ready"},  64'(bus.b_ready),  64'(br));
    endtask

    // One arbitration edge from the rules: B wins when queued and A absent
    // or starved, otherwise A; nothing is decided the cycle after a write.
    task automatic model_edge();
        bit ga, gbv, ready;
        ga    = 1'b0;
        gbv   = 1'b0;
        ready = (m_q.size() < 2);
        if (!m_in_write && !bus.bank_busy) begin
            if (m_q.size() > 0 && (!bus.a_req || m_starve == int'(STARVE_MAX))) gbv = 1'b1;
            else if (bus.a_req) ga = 1'b1;
        end
        if (gbv || m_q.size() == 0) m_starve = 0;
        else if (ga) m_starve = (m_starve < int'(STARVE_MAX)) ? m_starve + 1 : int'(STARVE_MAX);
        e_rw  = ga | gbv;
        e_ack = ga;
        e_gb  = gbv;
        if (gbv) begin
            e_rd = m_q[0].rd;
            e_wd = m_q[0].d;
            void'(m_q.pop_front());
        end else if (ga) begin
            e_rd = bus.a_regdst;
            e_wd = bus.a_data;
        end
        if (bus.b_valid && ready) m_q.push_back('{bus.b_regdst, bus.b_data});
        m_in_write = ga | gbv;
        e_br = (m_q.size() < 2);
    endtask

    initial begin
        logic [31:0] w_data [5];
        logic        w_gb   [5];
        int          nw;
        int          ka;
        bit          a_pending;

        // a_req, a_rd, a_data, b_valid, b_rd, b_data, busy | RegWrite, ack, grant_b, RegDst, wr_data, b_ready
        vecs[0]  = '{1'b1, 2'b10, 32'h1234, 1'b0, 2'b00, 32'h0,    1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 32'h1234, 1'b1};
        vecs[1]  = '{1'b1, 2'b10, 32'h1234, 1'b0, 2'b00, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 32'h1234, 1'b1};
        vecs[2]  = '{1'b0, 2'b00, 32'h0,    1'b1, 2'b11, 32'hAAAA, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 32'h1234, 1'b1};
        vecs[3]  = '{1'b0, 2'b00, 32'h0,    1'b1, 2'b01, 32'hBBBB, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 32'h1234, 1'b0};
        vecs[4]  = '{1'b0, 2'b00, 32'h0,    1'b1, 2'b00, 32'hCCCC, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 32'h1234, 1'b0};
        vecs[5]  = '{1'b0, 2'b00, 32'h0,    1'b0, 2'b00, 32'h0,    1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 32'hAAAA, 1'b1};
        vecs[6]  = '{1'b0, 2'b00, 32'h0,    1'b0, 2'b00, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 32'hAAAA, 1'b1};
        vecs[7]  = '{1'b0, 2'b00, 32'h0,    1'b0, 2'b00, 32'h0,    1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 32'hBBBB, 1'b1};
        vecs[8]  = '{1'b0, 2'b00, 32'h0,    1'b0, 2'b00, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 32'hBBBB, 1'b1};
        vecs[9]  = '{1'b0, 2'b00, 32'h0,    1'b0, 2'b00, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 32'hBBBB, 1'b1};
        vecs[10] = '{1'b1, 2'b00, 32'h5555, 1'b0, 2'b00, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'hBBBB, 1'b1};
        vecs[11] = '{1'b1, 2'b00, 32'h5555, 1'b0, 2'b00, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'hBBBB, 1'b1};
        vecs[12] = '{1'b1, 2'b00, 32'h5555, 1'b0, 2'b00, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'hBBBB, 1'b1};
        vecs[13] = '{1'b1, 2'b00, 32'h5555, 1'b0, 2'b00, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'hBBBB, 1'b1};
        vecs[14] = '{1'b1, 2'b00, 32'h5555, 1'b0, 2'b00, 32'h0,    1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 32'h5555, 1'b1};
        vecs[15] = '{1'b0, 2'b00, 32'h0,    1'b0, 2'b00, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h5555, 1'b1};
        vecs[16] = '{1'b1, 2'b01, 32'h7777, 1'b1, 2'b10, 32'h8888, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 32'h7777, 1'b1};
        vecs[17] = '{1'b0, 2'b00, 32'h0,    1'b0, 2'b00, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 32'h7777, 1'b1};
        vecs[18] = '{1'b0, 2'b00, 32'h0,    1'b0, 2'b00, 32'h0,    1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 32'h8888, 1'b1};
        vecs[19] = '{1'b0, 2'b00, 32'h0,    1'b0, 2'b00, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 32'h8888, 1'b1};

        // Reset state
        reset = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0);
        tick();
        tick();
        check_outs("reset", 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b1);
        reset = 1'b1;

        // Directed vectors: single A, FIFO order/full, bank_busy, collision
        for (int i = 0; i < N_VEC; i++) begin
            drive(vecs[i].a_req, vecs[i].a_regdst, vecs[i].a_data,
                  vecs[i].b_valid, vecs[i].b_regdst, vecs[i].b_data, vecs[i].busy);
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].rw, vecs[i].ack, vecs[i].gb,
                       vecs[i].rd, vecs[i].wd, vecs[i].br);
        end

        // Starvation: B queued while A saturates -> A0 A1 A2 B0 A3
        ka = 0;
        drive(1'b1, 2'b00, 32'hA000_0000, 1'b1, 2'b11, 32'hB000_0000, 1'b1);
        tick();
        drive(1'b1, 2'b00, 32'hA000_0000, 1'b0, 2'b00, 32'h0, 1'b0);
        nw = 0;
        for (int c = 0; c < 20 && nw < 5; c++) begin
            tick();
            if (bus.RegWrite === 1'b1) begin
                w_data[nw] = bus.wr_data;
                w_gb[nw]   = bus.grant_b;
                nw++;
            end
            if (bus.a_ack === 1'b1) begin
                ka++;
                bus.a_data = 32'hA000_0000 + 32'(ka);
            end
        end
        bus.a_req = 1'b0;
        check("starve_write_count", 64'(nw), 64'd5);
        if (nw == 5) begin
            check("starve_w0", 64'({w_gb[0], w_data[0]}), 64'({1'b0, 32'hA000_0000}));
            check("starve_w1", 64'({w_gb[1], w_data[1]}), 64'({1'b0, 32'hA000_0001}));
            check("starve_w2", 64'({w_gb[2], w_data[2]}), 64'({1'b0, 32'hA000_0002}));
            check("starve_w3", 64'({w_gb[3], w_data[3]}), 64'({1'b1, 32'hB000_0000}));
            check("starve_w4", 64'({w_gb[4], w_data[4]}), 64'({1'b0, 32'hA000_0003}));
        end
        tick();
        tick();

        // Reset mid-WRITE with a B entry queued: outputs drop, entry lost
        drive(1'b0, 2'b00, 32'h0, 1'b1, 2'b01, 32'hDDDD, 1'b1);
        tick();
        drive(1'b1, 2'b11, 32'hEEEE, 1'b0, 2'b00, 32'h0, 1'b0);
        tick();
        check("rst_pre_RegWrite", 64'(bus.RegWrite), 64'd1);
        reset = 1'b0;
        #1;
        check_outs("rst_mid", 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b1);
        bus.a_req = 1'b0;
        tick();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("rst_after%0d_RegWrite", c), 64'(bus.RegWrite), 64'd0);
        end

        // Randomized traffic vs reference model
        reset = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0);
        tick();
        reset = 1'b1;
        m_q.delete();
        m_starve   = 0;
        m_in_write = 1'b0;
        e_rd       = 2'b00;
        e_wd       = 32'h0;
        a_pending  = 1'b0;
        for (int c = 0; c < N_RND; c++) begin
            if (!a_pending && $urandom_range(0, 1) == 1) begin
                a_pending    = 1'b1;
                bus.a_regdst = 2'($urandom_range(0, 3));
                bus.a_data   = $urandom;
            end
            bus.a_req     = a_pending;
            bus.b_valid   = ($urandom_range(0, 1) == 1);
            bus.b_regdst  = 2'($urandom_range(0, 3));
            bus.b_data    = $urandom;
            bus.bank_busy = ($urandom_range(0, 3) == 0);
            model_edge();
            tick();
            check_outs("rnd", e_rw, e_ack, e_gb, e_rd, e_wd, e_br);
            if (e_ack) a_pending = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
